// File: rtl/axi_master_bridge.sv
// -----------------------------------------------------------------------------
// axi_master_bridge
//   Single-outstanding AXI4 master. Turns a simple command + beat stream
//   interface into one aligned INCR burst at a time (read or write). Sits
//   between cache-refill / DMA logic and the memory-side AXI slave.
//
// Optional feature macro: AXI_MST_TIMEOUT_EN
//   When defined, a watchdog aborts a stalled transaction after TIMEOUT_CYCLES
//   cycles without an AXI handshake. It drops all valids/readies, returns to
//   IDLE and pulses o_done with o_err = 2'b11 (debug aid only).
//   When undefined, the FSM waits indefinitely and TIMEOUT_CYCLES is unused.
//
// Ports
//   i_clk / i_rst_n        clock, asynchronous active-low reset
//   i_cmd_*  / o_cmd_ready command (write flag, byte address, AXI len);
//                          o_cmd_ready is high only in IDLE
//   i_wr_* / o_wr_ready    write beat stream into the bridge
//   o_rd_* / i_rd_ready    read beat stream out of the bridge
//   o_done / o_err         one-cycle end-of-transaction pulse and its response
//   o_aw_* / i_aw_ready    AXI write address channel
//   o_w_*  / i_w_ready     AXI write data channel
//   i_b_*  / o_b_ready     AXI write response channel
//   o_ar_* / i_ar_ready    AXI read address channel
//   i_r_*  / o_r_ready     AXI read data channel
// -----------------------------------------------------------------------------
module axi_master_bridge #(
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 1,
   parameter int MST_ID         = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   // command
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic                        i_cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [7:0]                  i_cmd_len,
   // write beat stream
   input  logic [AXI_DATA_WIDTH-1:0]   i_wr_data,
   input  logic [AXI_DATA_WIDTH/8-1:0] i_wr_strb,
   input  logic                        i_wr_valid,
   output logic                        o_wr_ready,
   // read beat stream
   output logic [AXI_DATA_WIDTH-1:0]   o_rd_data,
   output logic                        o_rd_last,
   output logic                        o_rd_valid,
   input  logic                        i_rd_ready,
   // completion
   output logic                        o_done,
   output logic [1:0]                  o_err,
   // AXI AW
   output logic [AXI_ID_WIDTH-1:0]     o_aw_id,
   output logic [AXI_ADDR_WIDTH-1:0]   o_aw_addr,
   output logic [7:0]                  o_aw_len,
   output logic [2:0]                  o_aw_size,
   output logic [1:0]                  o_aw_burst,
   output logic                        o_aw_lock,
   output logic [3:0]                  o_aw_cache,
   output logic [2:0]                  o_aw_prot,
   output logic [3:0]                  o_aw_qos,
   output logic [3:0]                  o_aw_region,
   output logic [AXI_USER_WIDTH-1:0]   o_aw_user,
   output logic                        o_aw_valid,
   input  logic                        i_aw_ready,
   // AXI W
   output logic [AXI_DATA_WIDTH-1:0]   o_w_data,
   output logic [AXI_DATA_WIDTH/8-1:0] o_w_strb,
   output logic                        o_w_last,
   output logic [AXI_USER_WIDTH-1:0]   o_w_user,
   output logic                        o_w_valid,
   input  logic                        i_w_ready,
   // AXI B
   input  logic [AXI_ID_WIDTH-1:0]     i_b_id,
   input  logic [1:0]                  i_b_resp,
   input  logic [AXI_USER_WIDTH-1:0]   i_b_user,
   input  logic                        i_b_valid,
   output logic                        o_b_ready,
   // AXI AR
   output logic [AXI_ID_WIDTH-1:0]     o_ar_id,
   output logic [AXI_ADDR_WIDTH-1:0]   o_ar_addr,
   output logic [7:0]                  o_ar_len,
   output logic [2:0]                  o_ar_size,
   output logic [1:0]                  o_ar_burst,
   output logic                        o_ar_lock,
   output logic [3:0]                  o_ar_cache,
   output logic [2:0]                  o_ar_prot,
   output logic [3:0]                  o_ar_qos,
   output logic [3:0]                  o_ar_region,
   output logic [AXI_USER_WIDTH-1:0]   o_ar_user,
   output logic                        o_ar_valid,
   input  logic                        i_ar_ready,
   // AXI R
   input  logic [AXI_ID_WIDTH-1:0]     i_r_id,
   input  logic [AXI_DATA_WIDTH-1:0]   i_r_data,
   input  logic [1:0]                  i_r_resp,
   input  logic                        i_r_last,
   input  logic [AXI_USER_WIDTH-1:0]   i_r_user,
   input  logic                        i_r_valid,
   output logic                        o_r_ready
);

   localparam int STRB_W   = AXI_DATA_WIDTH / 8;
   localparam int SIZE_LSB = $clog2(STRB_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA
   } state_t;

   state_t                      r_state;
   state_t                      w_next;
   logic [AXI_ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]                  r_len;
   logic [7:0]                  r_cnt;
   logic [1:0]                  r_rerr;
   logic                        r_done;
   logic [1:0]                  r_err;

   logic                        w_cmd_hs;
   logic                        w_aw_hs;
   logic                        w_w_hs;
   logic                        w_b_hs;
   logic                        w_ar_hs;
   logic                        w_r_hs;
   logic                        w_beat_last;
   logic                        w_rd_end;
   logic [1:0]                  w_rsp_max;
   logic                        w_tmo;

   // Handshakes qualified by state so stray slave signals outside the
   // owning phase are ignored.
   assign w_cmd_hs    = i_cmd_valid & (r_state == S_IDLE);
   assign w_aw_hs     = (r_state == S_WR_ADDR) & i_aw_ready;
   assign w_w_hs      = (r_state == S_WR_DATA) & i_wr_valid & i_w_ready;
   assign w_b_hs      = (r_state == S_WR_RESP) & i_b_valid;
   assign w_ar_hs     = (r_state == S_RD_ADDR) & i_ar_ready;
   assign w_r_hs      = (r_state == S_RD_DATA) & i_r_valid & i_rd_ready;
   assign w_beat_last = (r_cnt == r_len);
   // r_last alone ends a read burst; the beat counter is write-only.
   assign w_rd_end    = w_r_hs & i_r_last;
   assign w_rsp_max   = (i_r_resp > r_rerr) ? i_r_resp : r_rerr;

`ifdef AXI_MST_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_any_hs;

   assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

   // Counts idle cycles since the last AXI handshake of the current
   // transaction; held at zero while IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_IDLE) || w_any_hs) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_tmo = (r_state != S_IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_tmo;
   assign w_tmo        = 1'b0;
   assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_cmd_valid) w_next = i_cmd_write ? S_WR_ADDR : S_RD_ADDR;
         S_WR_ADDR: if (w_aw_hs) w_next = S_WR_DATA;
         S_WR_DATA: if (w_w_hs && w_beat_last) w_next = S_WR_RESP;
         S_WR_RESP: if (w_b_hs) w_next = S_IDLE;
         S_RD_ADDR: if (w_ar_hs) w_next = S_RD_DATA;
         S_RD_DATA: if (w_rd_end) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (w_tmo) w_next = S_IDLE;
   end

   always_comb begin
      o_cmd_ready = 1'b0;
      o_aw_valid  = 1'b0;
      o_ar_valid  = 1'b0;
      o_w_valid   = 1'b0;
      o_wr_ready  = 1'b0;
      o_w_data    = '0;
      o_w_strb    = '0;
      o_w_last    = 1'b0;
      o_b_ready   = 1'b0;
      o_rd_valid  = 1'b0;
      o_r_ready   = 1'b0;
      case (r_state)
         S_IDLE:    o_cmd_ready = 1'b1;
         S_WR_ADDR: o_aw_valid  = 1'b1;
         S_WR_DATA: begin
            // W channel is a straight combinational pass-through of the
            // caller's beat stream while the burst is open.
            o_w_valid  = i_wr_valid;
            o_wr_ready = i_w_ready;
            o_w_data   = i_wr_data;
            o_w_strb   = i_wr_strb;
            o_w_last   = w_beat_last;
         end
         S_WR_RESP: o_b_ready   = 1'b1;
         S_RD_ADDR: o_ar_valid  = 1'b1;
         S_RD_DATA: begin
            o_rd_valid = i_r_valid;
            o_r_ready  = i_rd_ready;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr <= '0;
         r_len  <= '0;
         r_cnt  <= '0;
         r_rerr <= '0;
         r_done <= 1'b0;
         r_err  <= '0;
      end else begin
         r_done <= w_b_hs | w_rd_end | w_tmo;
         if (w_cmd_hs) begin
            // Bursts are always bus-aligned: drop the sub-beat address bits.
            r_addr <= {i_cmd_addr[AXI_ADDR_WIDTH-1:SIZE_LSB], {SIZE_LSB{1'b0}}};
            r_len  <= i_cmd_len;
            r_cnt  <= '0;
            r_rerr <= '0;
         end
         if (w_w_hs) r_cnt <= r_cnt + 1'b1;
         if (w_r_hs) r_rerr <= w_rsp_max;
         if (w_tmo) begin
            r_err <= 2'b11;
         end else if (w_b_hs) begin
            r_err <= i_b_resp;
         end else if (w_rd_end) begin
            // Worst response seen across the whole read burst, incl. this beat.
            r_err <= w_rsp_max;
         end
      end
   end

   assign o_done    = r_done;
   assign o_err     = r_err;
   assign o_rd_data = i_r_data;
   assign o_rd_last = i_r_last;

   // AW/AR fields come straight from registers loaded only at command
   // capture, so they stay stable while valid is asserted.
   assign o_aw_id     = AXI_ID_WIDTH'(MST_ID);
   assign o_aw_addr   = r_addr;
   assign o_aw_len    = r_len;
   assign o_aw_size   = 3'(SIZE_LSB);
   assign o_aw_burst  = 2'b01;
   assign o_aw_lock   = 1'b0;
   assign o_aw_cache  = 4'd0;
   assign o_aw_prot   = 3'd0;
   assign o_aw_qos    = 4'd0;
   assign o_aw_region = 4'd0;
   assign o_aw_user   = '0;
   assign o_w_user    = '0;

   assign o_ar_id     = AXI_ID_WIDTH'(MST_ID);
   assign o_ar_addr   = r_addr;
   assign o_ar_len    = r_len;
   assign o_ar_size   = 3'(SIZE_LSB);
   assign o_ar_burst  = 2'b01;
   assign o_ar_lock   = 1'b0;
   assign o_ar_cache  = 4'd0;
   assign o_ar_prot   = 3'd0;
   assign o_ar_qos    = 4'd0;
   assign o_ar_region = 4'd0;
   assign o_ar_user   = '0;

   // Slave-side sideband fields carry nothing this master acts on.
   logic w_unused;
   assign w_unused = ^{i_b_id, i_b_user, i_r_id, i_r_user, i_cmd_addr[SIZE_LSB-1:0]};

endmodule
